// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic two;
        logic neg;
    } booth_digit_t;

    localparam booth_digit_t DIG_ZERO = '{zero: 1'b1, two: 1'b0, neg: 1'b0};
    localparam booth_digit_t DIG_POS1 = '{zero: 1'b0, two: 1'b0, neg: 1'b0};
    localparam booth_digit_t DIG_POS2 = '{zero: 1'b0, two: 1'b1, neg: 1'b0};
    localparam booth_digit_t DIG_NEG1 = '{zero: 1'b0, two: 1'b0, neg: 1'b1};
    localparam booth_digit_t DIG_NEG2 = '{zero: 1'b0, two: 1'b1, neg: 1'b1};

    // Operands widen to N+2 bits and each step retires two of them.
    function automatic int unsigned iter_count(input int unsigned n);
        return (n / 2) + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: multiplier triplet {q1,q0,q_m1} to a signed digit.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit_c
);

    always_comb begin
        digit_c = DIG_ZERO;
        case (triplet)
            3'b001, 3'b010: digit_c = DIG_POS1;
            3'b011:         digit_c = DIG_POS2;
            3'b100:         digit_c = DIG_NEG2;
            3'b101, 3'b110: digit_c = DIG_NEG1;
            default:        digit_c = DIG_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_mult.sv
// Iterative radix-4 Booth multiplier with start/busy/done handshake and
// per-operation signed/unsigned mode; product holds until the next accepted start.
module booth_r4_mult
    import booth_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [N-1:0]     multiplier,
    input  logic [N-1:0]     multiplicand,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int unsigned W  = N + 2;
    localparam int unsigned AW = W + 2;
    localparam int unsigned PW = 2 * N;
    localparam int unsigned K  = iter_count(N);
    localparam int unsigned CW = $clog2(K);

    if ((N < 4) || ((N % 2) != 0)) begin : g_bad_n
        $error("booth_r4_mult: N must be even and >= 4");
    end

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   a_q, a_d;
    logic [W-1:0]    q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [W-1:0]    m_q, m_d;
    logic [PW-1:0]   product_q, product_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    booth_digit_t    digit_c;
    logic [W-1:0]    mplier_ext_c;
    logic [W-1:0]    mcand_ext_c;
    logic [AW-1:0]   m_ext_c;
    logic [AW-1:0]   addend_c;
    logic [AW-1:0]   a_sum_c;
    logic [AW-1:0]   a_sh_c;
    logic [W-1:0]    q_sh_c;

    booth_r4_recoder u_recoder (
        .triplet (q_q[1:0] == 2'b00 ? {q_q[1:0], qm1_q} : {q_q[1], q_q[0], qm1_q}),
        .digit_c (digit_c)
    );

    // Operand extension and one radix-4 step of the {A,Q,q_m1} datapath.
    always_comb begin
        mplier_ext_c = signed_mode ? {{2{multiplier[N-1]}}, multiplier}
                                   : {2'b00, multiplier};
        mcand_ext_c  = signed_mode ? {{2{multiplicand[N-1]}}, multiplicand}
                                   : {2'b00, multiplicand};
        m_ext_c      = {{2{m_q[W-1]}}, m_q};
        addend_c     = digit_c.two ? {m_ext_c[AW-2:0], 1'b0} : m_ext_c;
        if (digit_c.zero) begin
            addend_c = '0;
        end
        // Two guard bits above W keep -2M of the most-negative M in range.
        a_sum_c      = digit_c.neg ? (a_q - addend_c) : (a_q + addend_c);
        a_sh_c       = {{2{a_sum_c[AW-1]}}, a_sum_c[AW-1:2]};
        q_sh_c       = {a_sum_c[1:0], q_q[W-1:2]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = CW'(K - 1);
                    a_d     = '0;
                    q_d     = mplier_ext_c;
                    qm1_d   = 1'b0;
                    m_d     = mcand_ext_c;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d    = a_sh_c;
                q_d    = q_sh_c;
                qm1_d  = q_q[1];
                cnt_d  = cnt_q - CW'(1);
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = PW'({a_sh_c, q_sh_c});
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
